// File: rtl/relax_scheduler.sv
// ----------------------------------------------------------------------------
// relax_scheduler
//   Frame-level sequencer for the rope constraint-relaxation array. A frame
//   request latches the mouse target, then walks a one-hot phase word across
//   all 2*NODES_PER_CORE node slots for ITERATIONS full sweeps, waits
//   SETTLE_CYCLES for the node registers to settle and pulses done.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-low reset
//   frame_start  in   request one relaxation frame (sampled every edge)
//   halt         in   synchronous abort of the current frame
//   x_mouse_in   in   mouse x, captured on frame acceptance
//   y_mouse_in   in   mouse y, captured on frame acceptance
//   phase_en     out  one-hot node update enable, broadcast to all cores
//   x_mouse      out  latched mouse x, held for the whole frame
//   y_mouse      out  latched mouse y, held for the whole frame
//   busy         out  frame in progress (RUN, SETTLE, DONE)
//   done         out  single-cycle pulse when a frame completes
//   iter_count   out  index of the current sweep (0-based)
//   frame_count  out  completed frames, wraps at 2^32
//   overrun      out  sticky: frame_start seen while a frame was in progress
// ----------------------------------------------------------------------------
module relax_scheduler #(
    parameter int NODES_PER_CORE = 5,
    parameter int ITERATIONS     = 8,
    parameter int SETTLE_CYCLES  = 2,
    parameter int ITER_W         = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic                          halt,
    input  logic [31:0]                   x_mouse_in,
    input  logic [31:0]                   y_mouse_in,
    output logic [2*NODES_PER_CORE-1:0]   phase_en,
    output logic [31:0]                   x_mouse,
    output logic [31:0]                   y_mouse,
    output logic                          busy,
    output logic                          done,
    output logic [ITER_W-1:0]             iter_count,
    output logic [31:0]                   frame_count,
    output logic                          overrun
);

    localparam int PW = 2 * NODES_PER_CORE;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [ITER_W-1:0] LAST_ITER   = ITER_W'(ITERATIONS - 1);
    localparam logic [SW-1:0]     LAST_SETTLE = SW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0]     PHASE_FIRST = PW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_SETTLE,
        ST_DONE
    } state_e;

    state_e            state_q,    state_d;
    logic [PW-1:0]     phase_q,    phase_d;
    logic [31:0]       x_q,        x_d;
    logic [31:0]       y_q,        y_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic [ITER_W-1:0] iter_q,     iter_d;
    logic [31:0]       frames_q,   frames_d;
    logic              overrun_q,  overrun_d;
    logic [SW-1:0]     settle_q,   settle_d;

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case statement so no
        // path leaves it unassigned; otherwise synthesis infers a latch.
        state_d   = state_q;
        phase_d   = phase_q;
        x_d       = x_q;
        y_d       = y_q;
        busy_d    = busy_q;
        done_d    = done_q;
        iter_d    = iter_q;
        frames_d  = frames_q;
        overrun_d = overrun_q;
        settle_d  = settle_q;

        // A request that arrives while any frame is in flight is dropped,
        // but remembered until reset.
        if (frame_start && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // halt has priority over a new request
                if (frame_start && !halt) begin
                    x_d     = x_mouse_in;
                    y_d     = y_mouse_in;
                    phase_d = PHASE_FIRST;
                    iter_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (halt) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    iter_d  = '0;
                end else if (phase_q[PW-1]) begin
                    // End of a sweep: either wrap to slot 0 for the next
                    // sweep or leave the array idle for settling.
                    if (iter_q == LAST_ITER) begin
                        phase_d  = '0;
                        settle_d = '0;
                        state_d  = ST_SETTLE;
                    end else begin
                        phase_d = PHASE_FIRST;
                        iter_d  = iter_q + 1'b1;
                    end
                end else begin
                    phase_d = {phase_q[PW-2:0], 1'b0};
                end
            end

            ST_SETTLE: begin
                if (halt) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    iter_d  = '0;
                end else if (settle_q == LAST_SETTLE) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end

            ST_DONE: begin
                if (halt) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    iter_d  = '0;
                end else begin
                    // The frame only counts once its done pulse has been seen.
                    done_d   = 1'b0;
                    busy_d   = 1'b0;
                    frames_d = frames_q + 32'd1;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge value of the others, independent of statement order.
        if (!reset) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            iter_q    <= '0;
            frames_q  <= '0;
            overrun_q <= 1'b0;
            settle_q  <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            x_q       <= x_d;
            y_q       <= y_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            iter_q    <= iter_d;
            frames_q  <= frames_d;
            overrun_q <= overrun_d;
            settle_q  <= settle_d;
        end
    end

    assign phase_en    = phase_q;
    assign x_mouse     = x_q;
    assign y_mouse     = y_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign iter_count  = iter_q;
    assign frame_count = frames_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_relax_scheduler.sv
// ----------------------------------------------------------------------------
// tb_relax_scheduler
//   Directed bench for relax_scheduler (N=5, ITERATIONS=2, SETTLE_CYCLES=2).
//   A frame-timeline model predicts every output from the number of cycles
//   since acceptance; a compare process checks it on every falling edge, and
//   directed sequences add hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_relax_scheduler;

    localparam int N      = 5;
    localparam int IT     = 2;
    localparam int SET    = 2;
    localparam int ITER_W = 8;
    localparam int PW     = 2 * N;
    localparam int RUN_K  = PW * IT;        // cycles of phase activity
    localparam int DONE_K = RUN_K + SET;    // cycle index of the done pulse

    logic              clk = 1'b0;
    logic              reset;
    logic              frame_start;
    logic              halt;
    logic [31:0]       x_mouse_in;
    logic [31:0]       y_mouse_in;
    logic [PW-1:0]     phase_en;
    logic [31:0]       x_mouse;
    logic [31:0]       y_mouse;
    logic              busy;
    logic              done;
    logic [ITER_W-1:0] iter_count;
    logic [31:0]       frame_count;
    logic              overrun;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    relax_scheduler #(
        .NODES_PER_CORE (N),
        .ITERATIONS     (IT),
        .SETTLE_CYCLES  (SET),
        .ITER_W         (ITER_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .halt        (halt),
        .x_mouse_in  (x_mouse_in),
        .y_mouse_in  (y_mouse_in),
        .phase_en    (phase_en),
        .x_mouse     (x_mouse),
        .y_mouse     (y_mouse),
        .busy        (busy),
        .done        (done),
        .iter_count  (iter_count),
        .frame_count (frame_count),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame timeline model: a frame is just "k cycles since acceptance".
    // ------------------------------------------------------------------
    bit          m_in;
    int          m_k;
    logic [31:0] m_x, m_y, m_fc;
    bit          m_ovr;
    int          m_iter_idle;

    bit          n_in;
    int          n_k;
    logic [31:0] n_x, n_y, n_fc;
    bit          n_ovr;
    int          n_iter_idle;

    always @(posedge clk) begin
        n_in = m_in; n_k = m_k; n_x = m_x; n_y = m_y;
        n_fc = m_fc; n_ovr = m_ovr; n_iter_idle = m_iter_idle;
        if (!reset) begin
            n_in = 1'b0; n_k = 0; n_x = '0; n_y = '0;
            n_fc = '0; n_ovr = 1'b0; n_iter_idle = 0;
        end else if (m_in) begin
            if (frame_start) n_ovr = 1'b1;
            if (halt) begin
                n_in = 1'b0;
                n_iter_idle = 0;
            end else if (m_k == DONE_K) begin
                n_in = 1'b0;
                n_fc = m_fc + 32'd1;
                n_iter_idle = IT - 1;
            end else begin
                n_k = m_k + 1;
            end
        end else if (frame_start && !halt) begin
            n_in = 1'b1;
            n_k  = 0;
            n_x  = x_mouse_in;
            n_y  = y_mouse_in;
        end
        m_in <= n_in; m_k <= n_k; m_x <= n_x; m_y <= n_y;
        m_fc <= n_fc; m_ovr <= n_ovr; m_iter_idle <= n_iter_idle;
    end

    function automatic logic [31:0] exp_phase();
        logic [31:0] one = 32'd1;
        if (m_in && m_k < RUN_K) return one << (m_k % PW);
        return 32'd0;
    endfunction

    function automatic logic [31:0] exp_iter();
        if (m_in) return (m_k < RUN_K) ? 32'(m_k / PW) : 32'(IT - 1);
        return 32'(m_iter_idle);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",        32'(busy),        32'(m_in));
            check("done",        32'(done),        32'(m_in && m_k == DONE_K));
            check("phase_en",    32'(phase_en),    exp_phase());
            check("iter_count",  32'(iter_count),  exp_iter());
            check("frame_count", frame_count,      m_fc);
            check("overrun",     32'(overrun),     32'(m_ovr));
            check("x_mouse",     x_mouse,          m_x);
            check("y_mouse",     y_mouse,          m_y);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // Returns at the falling edge where the frame is in cycle k=0.
    task automatic start_frame(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        frame_start = 1'b1;
        x_mouse_in  = x;
        y_mouse_in  = y;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [PW-1:0]     ph_log [40];
    logic [ITER_W-1:0] it_log [40];
    logic              dn_log [40];

    initial begin
        int          done_k;
        logic [31:0] fc_before;

        reset       = 1'b0;
        frame_start = 1'b0;
        halt        = 1'b0;
        x_mouse_in  = '0;
        y_mouse_in  = '0;

        // 1. Reset for two cycles, then release
        wait_cycles(2);
        chk_en = 1'b1;
        reset  = 1'b1;
        wait_cycles(3);
        check("t1_phase_idle", 32'(phase_en), 32'h0);
        check("t1_busy_idle",  32'(busy),     32'h0);
        check("t1_fc_idle",    frame_count,   32'h0);

        // 2. Single frame, logged cycle by cycle from acceptance
        start_frame(32'h10, 32'h20);
        for (int i = 0; i < 40; i++) begin
            ph_log[i] = phase_en;
            it_log[i] = iter_count;
            dn_log[i] = done;
            @(negedge clk);
        end
        done_k = -1;
        for (int i = 0; i < 40; i++) begin
            if (dn_log[i] && done_k < 0) done_k = i;
        end
        check("t2_phase_k0",  32'(ph_log[0]),  32'h001);
        check("t2_phase_k1",  32'(ph_log[1]),  32'h002);
        check("t2_phase_k9",  32'(ph_log[9]),  32'h200);
        check("t2_phase_k10", 32'(ph_log[10]), 32'h001);
        check("t2_iter_k10",  32'(it_log[10]), 32'd1);
        check("t2_phase_k19", 32'(ph_log[19]), 32'h200);
        check("t2_phase_k20", 32'(ph_log[20]), 32'h000);
        check("t2_phase_k21", 32'(ph_log[21]), 32'h000);
        check("t2_done_k",    32'(done_k),     32'd22);
        check("t2_done_len",  32'(dn_log[23]), 32'd0);
        check("t2_fc",        frame_count,     32'd1);
        check("t2_x_held",    x_mouse,         32'h10);
        check("t2_y_held",    y_mouse,         32'h20);
        check("t2_overrun",   32'(overrun),    32'd0);

        // 3. frame_start held across three back-to-back frames
        @(negedge clk);
        frame_start = 1'b1;
        x_mouse_in  = 32'h33;
        wait_cycles(50);
        frame_start = 1'b0;
        wait_cycles(30);
        check("t3_fc",      frame_count,  32'd4);
        check("t3_overrun", 32'(overrun), 32'd1);
        check("t3_busy",    32'(busy),    32'd0);

        // 4. halt in the seventh RUN cycle, then a normal frame
        fc_before = frame_count;
        start_frame(32'h44, 32'h55);
        wait_cycles(6);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        check("t4_phase_halt", 32'(phase_en),   32'h0);
        check("t4_busy_halt",  32'(busy),       32'h0);
        check("t4_iter_halt",  32'(iter_count), 32'h0);
        check("t4_fc_halt",    frame_count,     fc_before);
        wait_cycles(5);
        start_frame(32'h66, 32'h77);
        wait_cycles(30);
        check("t4_fc_after", frame_count, fc_before + 32'd1);
        check("t4_x_after",  x_mouse,     32'h66);

        // halt in IDLE blocks a request
        halt        = 1'b1;
        frame_start = 1'b1;
        wait_cycles(3);
        check("idle_halt_busy", 32'(busy), 32'd0);
        halt        = 1'b0;
        frame_start = 1'b0;
        wait_cycles(2);

        // 6. x_mouse_in toggles throughout a frame
        start_frame(32'hABCD, 32'h1234);
        for (int i = 0; i < 30; i++) begin
            x_mouse_in = $urandom;
            y_mouse_in = $urandom;
            @(negedge clk);
        end
        check("t6_x_held", x_mouse,     32'hABCD);
        check("t6_y_held", y_mouse,     32'h1234);
        check("t6_fc",     frame_count, 32'd6);

        // 5. reset in the first SETTLE cycle
        start_frame(32'h99, 32'h88);
        wait_cycles(20);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("t5_phase",   32'(phase_en),   32'h0);
        check("t5_busy",    32'(busy),       32'h0);
        check("t5_done",    32'(done),       32'h0);
        check("t5_fc",      frame_count,     32'h0);
        check("t5_overrun", 32'(overrun),    32'h0);
        check("t5_x",       x_mouse,         32'h0);
        check("t5_iter",    32'(iter_count), 32'h0);
        wait_cycles(10);
        check("t5_no_done_fc", frame_count, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
